// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package load_store_unit_pkg;

  localparam logic [1:0] LSU_SZ_B = 2'b00;
  localparam logic [1:0] LSU_SZ_H = 2'b01;
  localparam logic [1:0] LSU_SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } lsu_state_e;

  // funct3 size 2'b10 and 2'b11 are both treated as a full word.
  function automatic logic is_word(input logic [1:0] sz);
    return sz[1];
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Variable-latency req/ack data-memory bus between the load/store unit and memory.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane steering for stores, extract/extend for loads, misalign detect.
// Misalign detection is only active when LSU_MISALIGN_TRAP_EN is defined.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic        mis,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        sext;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    if (st_size == LSU_SZ_B) begin
      st_be    = 4'b0001 << st_addr_lo;
      st_wdata = {4{st_data[7:0]}};
    end else if (st_size == LSU_SZ_H) begin
      st_be    = 4'b0011 << {st_addr_lo[1], 1'b0};
      st_wdata = {2{st_data[15:0]}};
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = ((st_size == LSU_SZ_H) && st_addr_lo[0]) ||
               (is_word(st_size) && (st_addr_lo != 2'b00));
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    ld_byte = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
    ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    sext    = ~ld_funct3[2];
    case (ld_funct3[1:0])
      LSU_SZ_B: ld_data = {{24{ld_byte[7] & sext}}, ld_byte};
      LSU_SZ_H: ld_data = {{16{ld_half[15] & sext}}, ld_half};
      default:  ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: one load/store per MEM phase over a req/ack bus with timeout.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses without a bus cycle.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_rd,
  input  logic               mem_we,
  input  logic [2:0]         funct3,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [31:0]        store_data,
  output logic [31:0]        load_data,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               misaligned,
  load_store_unit_if.master  bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              mis_q, mis_d;
  logic [31:0]       load_data_q, load_data_d;

  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic              al_mis;
  logic [31:0]       al_ld;
  logic              in_req;

  // Steering and misalign detect look at the live request; extraction at the latched one.
  lsu_align u_align (
    .st_size    (funct3[1:0]),
    .st_addr_lo (addr[1:0]),
    .st_data    (store_data),
    .st_be      (al_be),
    .st_wdata   (al_wdata),
    .mis        (al_mis),
    .ld_funct3  (funct3_q),
    .ld_addr_lo (addr_q[1:0]),
    .ld_rdata   (bus.bus_rdata),
    .ld_data    (al_ld)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    mis_d       = mis_q;
    load_data_d = load_data_q;
    case (state_q)
      IDLE: begin
        if (mem_rd || mem_we) begin
          we_d     = mem_we;
          funct3_d = funct3;
          addr_d   = addr;
          be_d     = al_be;
          wdata_d  = al_wdata;
          cnt_d    = '0;
          err_d    = 1'b0;
          mis_d    = al_mis;
          state_d  = al_mis ? DONE : REQ;
        end
      end
      REQ: begin
        if (bus.bus_ack) begin
          state_d = DONE;
          if (!we_q) load_data_d = al_ld;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      mis_q       <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      mis_q       <= mis_d;
      load_data_q <= load_data_d;
    end
  end

  // Bus fields are only driven while a request is outstanding.
  assign in_req        = (state_q == REQ);
  assign bus.bus_req   = in_req;
  assign bus.bus_we    = in_req & we_q;
  assign bus.bus_addr  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus.bus_be    = in_req ? be_q : 4'b0000;
  assign bus.bus_wdata = in_req ? wdata_q : 32'h0;

  assign load_data  = load_data_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign err        = done & err_q;
  assign misaligned = done & mis_q;

endmodule
